bitplane_serializer: RTL
========================

// Module: bitplane_serializer
// PURPOSE
//  Parametrised bit-plane serializer: on start, reads DEPTH words of DATA_W bits from a
//  sync-read buffer, then emits DATA_W serial frames, one per bit-plane, on sen/sd.
//  Each frame = plane index (PW bits, MSB first) + one bit from every stored word,
//  word DEPTH-1 first down to word 0. Adds start/busy/done handshake and an idle gap.
//  Sits between the frame buffer and the serial display/link driver.
// PARAMETERS
//  DATA_W     8   word width = number of planes; power of 2, >=2; PW = $clog2(DATA_W)
//  DEPTH      18  words per transfer; 1..2**AW
//  AW         5   buffer address width
//  GAP        1   idle cycles (sen=1) after each frame; 0 allowed
//  MSB_FIRST  1   1: plane p carries bit DATA_W-1-p; 0: plane p carries bit p
// PORTS
//  clk    in   1       clock, all state on posedge
//  rst    in   1       reset, asynchronous, active-high
//  start  in   1       1-cycle request; sampled only in IDLE
//  busy   out  1       high from the cycle after start accept until done
//  done   out  1       1-cycle pulse after last frame (incl. its gap)
//  rb_rw  out  1       buffer R/W; held 1 (read) always
//  rb_a   out  AW      buffer read address
//  rb_q   in   DATA_W  buffer read data, valid 1 cycle after rb_a
//  sen    out  1       serial enable, active-low: 0 for every address/data bit
//  sd     out  1       serial data
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, rb_rw=1, rb_a=0, sen=1, sd=0,
//   counters 0. Word store contents not cleared (fully rewritten each transfer).
//  All outputs registered. States: IDLE, LOAD, ADDR, DATA, GAP, FIN.
//  IDLE: start=1 -> LOAD, busy=1, rb_a=0. start while busy: ignored, no queuing.
//  LOAD: rb_a steps 0..DEPTH-1 one per cycle; rb_q captured next cycle into word[rb_a-1];
//   DEPTH+1 cycles total; then ADDR with plane p=0; rb_a returns to 0.
//  ADDR: PW cycles, sen=0, sd=p[PW-1]..p[0]; -> DATA.
//  DATA: DEPTH cycles, sen=0, sd=word[w][bit] for w=DEPTH-1..0, bit per MSB_FIRST.
//   Last bit -> GAP (or directly next ADDR / FIN if GAP=0).
//  GAP: GAP cycles, sen=1, sd=0. Then p<DATA_W-1: p++, ADDR; else FIN.
//  FIN: done=1, busy=0, sen=1 for one cycle; -> IDLE. start in FIN ignored.
//  Frame = PW+DEPTH cycles sen=0 contiguous; transfer = (DEPTH+1)+DATA_W*(PW+DEPTH+GAP)
//   cycles from start accept to done pulse.
//  Counters: plane counter PW bits, word counter $clog2(DEPTH+1) bits; no wrap inside a
//   transfer; plane counter terminates at DATA_W-1 (never wraps to 0 mid-transfer).
//  sd = 0 whenever sen=1.
//  Reset mid-transfer: outputs at reset values immediately; next start runs full
//   transfer including reload from buffer.
// STRUCTURE
//  Package bitplane_pkg: state enum, PW/counter-width localparams, bit-select function
//   (plane, MSB_FIRST) -> bit index.
//  Sub-module bitplane_frame_tx: given word store + plane index, drives ADDR/DATA/GAP
//   sequence; top owns LOAD, handshake, plane loop.
// TESTING
//  1 Assert rst mid-cycle -> same cycle sen=1, sd=0, busy=0, done=0, rb_rw=1, rb_a=0.
//  2 Defaults, word[17]=8'hFF, others 0, start -> every frame: addr bits then 1 followed
//    by 17 zeros; plane addrs 000,001,...,111 in order; done 8*22+19=195 cycles after accept.
//  3 Defaults, word[i]=8'h80 only for i=0 -> plane 0 data=17 zeros then 1; planes 1-7 all 0;
//    repeat with MSB_FIRST=0 -> only plane 7 carries the 1.
//  4 start pulsed during LOAD and DATA -> ignored, exactly one done pulse, stream identical.
//  5 rst during plane 3 DATA, release, start -> full fresh 8-frame stream, buffer re-read 0..17.
//  6 DATA_W=4, DEPTH=5, GAP=0 -> PW=2, frames 7 cycles back-to-back sen=0, done after 6+28 cycles.

Source files
------------

// File: rtl/bitplane_pkg.sv
// rtl/bitplane_pkg.sv - shared types and width/bit-select helpers for the bit-plane serializer
// Purpose: controller and frame-transmitter state enums, counter-width and plane-to-bit helpers.
// Ports: none (package).
package bitplane_pkg;

    // Transfer-level control: buffer load, frame loop, completion pulse.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_FIN
    } ctrl_state_t;

    // Per-frame sequencing inside the transmitter.
    typedef enum logic [1:0] {
        FR_IDLE,
        FR_ADDR,
        FR_DATA,
        FR_GAP
    } frame_state_t;

    function automatic int plane_width(input int data_w);
        return $clog2(data_w);
    endfunction

    // One down-counter serves the address, data and gap phases, so it must hold the largest.
    function automatic int frame_cnt_width(input int depth, input int pw, input int gap);
        int m;
        m = depth;
        if (pw > m) m = pw;
        if (gap > m) m = gap;
        return $clog2(m + 1);
    endfunction

    function automatic int bit_sel(input int plane, input int data_w, input bit msb_first);
        return msb_first ? (data_w - 1 - plane) : plane;
    endfunction

endpackage

// File: rtl/bitplane_frame_tx.sv
// rtl/bitplane_frame_tx.sv - emits one frame: plane address, one bit per stored word, idle gap
// Purpose: on i_start latches i_plane and drives ADDR (PW bits, MSB first), DATA (word DEPTH-1..0), GAP.
// Ports: clk, rst (async, active-high), i_start (begin frame next cycle), i_plane, i_words (word store),
//        o_end (combinational: current cycle is the last of the frame incl. gap), o_sen, o_sd (registered).
import bitplane_pkg::*;

module bitplane_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 18,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [plane_width(DATA_W)-1:0] i_plane,
    input  logic [DEPTH-1:0][DATA_W-1:0]   i_words,
    output logic                           o_end,
    output logic                           o_sen,
    output logic                           o_sd
);
    localparam int PW = plane_width(DATA_W);
    localparam int CW = frame_cnt_width(DEPTH, PW, GAP);
    localparam logic [CW-1:0] ADDR_LAST = CW'(PW - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? (GAP - 1) : 0);

    frame_state_t    r_state, w_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [PW-1:0]   r_plane, w_plane_n;
    logic            r_sen, r_sd, w_sen_n, w_sd_n, w_end;
    logic [DEPTH-1:0] w_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FR_IDLE;
            r_cnt   <= '0;
            r_plane <= '0;
            r_sen   <= 1'b1;
            r_sd    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_plane <= w_plane_n;
            r_sen   <= w_sen_n;
            r_sd    <= w_sd_n;
        end
    end

    // Counter runs down to 0 in every phase; the phase ends on 0.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_plane_n = r_plane;
        w_end     = 1'b0;
        case (r_state)
            FR_ADDR: begin
                if (r_cnt == '0) begin
                    w_state_n = FR_DATA;
                    w_cnt_n   = DATA_LAST;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            FR_DATA: begin
                if (r_cnt == '0) begin
                    if (GAP == 0) begin
                        w_end     = 1'b1;
                        w_state_n = FR_IDLE;
                    end else begin
                        w_state_n = FR_GAP;
                        w_cnt_n   = GAP_LAST;
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            FR_GAP: begin
                if (r_cnt == '0) begin
                    w_end     = 1'b1;
                    w_state_n = FR_IDLE;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: ;
        endcase
        // A new frame may start on the last cycle of the previous one (back-to-back frames).
        if (i_start) begin
            w_state_n = FR_ADDR;
            w_cnt_n   = ADDR_LAST;
            w_plane_n = i_plane;
        end
    end

    // Column of the word store that the upcoming plane transmits.
    always_comb begin
        w_col = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (bit_sel(int'(w_plane_n), DATA_W, MSB_FIRST) == j) begin
                for (int i = 0; i < DEPTH; i++) begin
                    w_col[i] = i_words[i][j];
                end
            end
        end
    end

    // Outputs are computed from next state so the pins come straight from flops.
    always_comb begin
        w_sd_n  = 1'b0;
        w_sen_n = !((w_state_n == FR_ADDR) || (w_state_n == FR_DATA));
        if (w_state_n == FR_ADDR) begin
            for (int i = 0; i < PW; i++) begin
                if (w_cnt_n == CW'(i)) w_sd_n = w_plane_n[i];
            end
        end else if (w_state_n == FR_DATA) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cnt_n == CW'(i)) w_sd_n = w_col[i];
            end
        end
    end

    assign o_end = w_end;
    assign o_sen = r_sen;
    assign o_sd  = r_sd;

endmodule

// File: rtl/bitplane_serializer.sv
// rtl/bitplane_serializer.sv - loads DEPTH words from a sync-read buffer and sends DATA_W bit-plane frames
// Purpose: start/busy/done handshake, buffer load, plane loop; frame bits come from bitplane_frame_tx.
// Ports: clk, rst (async, active-high), start, busy, done, rb_rw (always read), rb_a, rb_q (1-cycle latency),
//        sen (active-low frame enable), sd (serial data).
import bitplane_pkg::*;

module bitplane_serializer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 18,
    parameter int AW        = 5,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rb_rw,
    output logic [AW-1:0]     rb_a,
    input  logic [DATA_W-1:0] rb_q,
    output logic              sen,
    output logic              sd
);
    localparam int PW = plane_width(DATA_W);
    localparam int LW = $clog2(DEPTH + 1);

    ctrl_state_t               r_state, w_state_n;
    logic [LW-1:0]             r_ld_cnt, w_ld_n;
    logic [PW-1:0]             r_plane, w_plane_n;
    logic [AW-1:0]             r_rb_a, w_rb_a_n;
    logic                      r_busy, r_done, r_rb_rw;
    logic                      w_frame_start, w_frame_end;
    logic [DEPTH-1:0][DATA_W-1:0] r_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ld_cnt <= '0;
            r_plane  <= '0;
            r_rb_a   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rb_rw  <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_ld_cnt <= w_ld_n;
            r_plane  <= w_plane_n;
            r_rb_a   <= w_rb_a_n;
            r_busy   <= (w_state_n == ST_LOAD) || (w_state_n == ST_XFER);
            r_done   <= (w_state_n == ST_FIN);
            r_rb_rw  <= 1'b1;
        end
    end

    // Load cycle k (k >= 1) sees the data for the address issued in cycle k-1.
    // The store is fully rewritten every transfer, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if ((r_state == ST_LOAD) && (r_ld_cnt == LW'(i + 1))) r_words[i] <= rb_q;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_ld_n        = r_ld_cnt;
        w_plane_n     = r_plane;
        w_rb_a_n      = r_rb_a;
        w_frame_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_n = ST_LOAD;
                    w_ld_n    = '0;
                    w_rb_a_n  = '0;
                end
            end
            ST_LOAD: begin
                if (r_ld_cnt == LW'(DEPTH)) begin
                    w_state_n     = ST_XFER;
                    w_plane_n     = '0;
                    w_rb_a_n      = '0;
                    w_frame_start = 1'b1;
                end else begin
                    w_ld_n   = r_ld_cnt + 1'b1;
                    w_rb_a_n = (w_ld_n < LW'(DEPTH)) ? AW'(w_ld_n) : '0;
                end
            end
            ST_XFER: begin
                if (w_frame_end) begin
                    if (r_plane == PW'(DATA_W - 1)) begin
                        w_state_n = ST_FIN;
                    end else begin
                        w_plane_n     = r_plane + 1'b1;
                        w_frame_start = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    bitplane_frame_tx #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .GAP       (GAP),
        .MSB_FIRST (MSB_FIRST)
    ) u_frame_tx (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_frame_start),
        .i_plane (w_plane_n),
        .i_words (r_words),
        .o_end   (w_frame_end),
        .o_sen   (sen),
        .o_sd    (sd)
    );

    assign busy  = r_busy;
    assign done  = r_done;
    assign rb_rw = r_rb_rw;
    assign rb_a  = r_rb_a;

endmodule
